n64_rx: RTL and testbench
=========================

# n64_rx

Receiver for the N64 controller one-wire response frame. Once armed by the host-side command logic, it watches the synchronized data line and decodes NBITS pulse-width-encoded bits, MSB first, plus the stop bit. It then presents the word with a one-cycle valid strobe, or flags a timeout if the controller goes silent. It sits between the open-drain pad input and the button/stick register file, alongside the command transmitter that drives the same line.

## Interface
- `US`, 50: clock cycles per microsecond (50 MHz clk).
- `NBITS`, 32: data bits per response frame.
- `TIMEOUT`, 5000: max cycles allowed waiting for any single edge (100 us at default).
- `clk`  in  1  system clock, the only clock.
- `reset`  in  1  synchronous, active-high; returns the block to IDLE.
- `start`  in  1  one-cycle arm pulse, issued when the transmitter finishes its stop bit.
- `din`  in  1  raw data line (asynchronous, idle high).
- `data`  out  NBITS  last successfully received word, MSB = first bit on the wire.
- `valid`  out  1  one-cycle pulse when `data` updates.
- `busy`  out  1  high from the cycle after an accepted `start` until done or error.
- `err`  out  1  one-cycle pulse on timeout.

## Operation
- `din` passes through a 2-FF synchronizer, giving `ds`. A third register `ds_q` is used for edge detection.
  - Falling edge: `ds_q==1 && ds==0`.
  - Rising edge: `ds_q==0 && ds==1`.
- Bit encoding:
  - '0' is 3 us low then 1 us high.
  - '1' is 1 us low then 3 us high.
  - The bit value is the level of `ds` exactly 2*US cycles after the detected falling edge.
- States:
  - IDLE: `busy`=0. `start` clears the bit counter and timeout counter, then goes to WAIT_FALL.
  - WAIT_FALL: a falling edge restarts the sample timer and goes to SAMPLE.
  - SAMPLE: when the sample timer expires, shift `ds` into the LSB of the shift register, increment the bit count, and go to WAIT_RISE.
  - WAIT_RISE: on a rising edge:
    - if bit count == NBITS, go to STOP_FALL;
    - otherwise go to WAIT_FALL.
  - STOP_FALL: a falling edge goes to STOP_RISE.
  - STOP_RISE: a rising edge copies the shift register to `data`, pulses `valid`, and goes to IDLE.
- Timeout:
  - The timeout counter clears on every state transition. It increments in every state except IDLE and SAMPLE.
  - Reaching TIMEOUT pulses `err` and goes to IDLE. `data` is left unchanged and the partial word is discarded.
- Corner cases:
  - `start` while `busy`=1 is ignored.
  - `start` coinciding with `reset` is ignored.
  - `reset` mid-frame: next cycle is IDLE with all outputs at reset values. The partial frame is lost, and a later `start` must be issued.
- Bit counter width: $clog2(NBITS+1). Timeout counter width: $clog2(TIMEOUT+1). Sample timer width: $clog2(2*US)+1. No counter wraps: each saturates or is reloaded.

## Timing
- Reset values: `data`=0, `valid`=0, `busy`=0, `err`=0, state IDLE, synchronizer flops 1.
- `start` at cycle t makes `busy`=1 at t+1.
- Edge detection lags `din` by 3 cycles: 2 sync stages plus the `ds_q` register.
- Sample point is 2*US cycles after the falling edge is detected, ±1 cycle.
- `valid` and `data` update together, 1 cycle after the stop-bit rising edge is detected. `busy` falls in that same cycle.
- `err` pulses exactly TIMEOUT cycles after the last state transition. `busy` falls with it.
- `valid` and `err` are never high together.

## Structure
- Shared package n64_pkg holds:
  - the state enum: IDLE, WAIT_FALL, SAMPLE, WAIT_RISE, STOP_FALL, STOP_RISE;
  - protocol constants: bit period 4 us, sample point 2 us, default US.
- The sample timer is an instance of the team's existing descending counter `counterM`, with M = 2*US-1.
  - Its reset is driven by falling-edge detection.
  - Its `empty` output marks the sample point.
- Synchronizer, edge detect, FSM, shift register and timeout counter live in n64_rx itself.

## Test plan
- Controller model drives 32'h8000_0000 plus stop bit, 4 us bit period, about 2 us after `start` -> one `valid` pulse, `data`=32'h8000_0000, `busy` low afterwards.
- Frame 32'hFFFF_FFFF, then a second `start` and frame 32'h1234_5678 -> two `valid` pulses, with `data` matching each word in order.
- `start` with `din` held high -> `err` at TIMEOUT cycles, `data` keeps its previous value, `valid` never asserts.
- Line stuck low after bit 10 -> `err` after TIMEOUT cycles in WAIT_RISE, then a clean frame of 32'h00FF_00FF is received correctly.
- Second `start` pulse mid-frame -> ignored, and the frame decodes correctly.
- `reset` asserted during bit 20 -> next cycle all outputs 0 and state IDLE. The rest of the frame on `din` produces no `valid` and no `err`.

Source files
------------

// File: rtl/n64_pkg.sv
// ----------------------------------------------------------------------------
// n64_pkg
// Shared definitions for the N64 controller one-wire receiver:
//   - state_e        : receiver FSM states
//   - US_DEFAULT     : clock cycles per microsecond at 50 MHz
//   - BIT_PERIOD_US  : nominal length of one data bit on the wire
//   - SAMPLE_POINT_US: distance from the falling edge to the bit sample point
//   - sample_cycles(): sample point expressed in clock cycles
// ----------------------------------------------------------------------------
package n64_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_FALL = 3'd1,
        S_SAMPLE    = 3'd2,
        S_WAIT_RISE = 3'd3,
        S_STOP_FALL = 3'd4,
        S_STOP_RISE = 3'd5
    } state_e;

    localparam int US_DEFAULT      = 50;
    localparam int BIT_PERIOD_US   = 4;
    localparam int SAMPLE_POINT_US = 2;

    function automatic int sample_cycles(input int us);
        return SAMPLE_POINT_US * us;
    endfunction

endpackage

// File: rtl/n64_rx_counterM.sv
// ----------------------------------------------------------------------------
// counterM
// Descending counter. A synchronous reset reloads it with M; otherwise it
// counts down by one per cycle and holds at zero.
//   clk   in  system clock
//   reset in  synchronous reload to M (active high)
//   empty out high while the count is zero
// ----------------------------------------------------------------------------
module counterM #(
    parameter int M = 99,
    parameter int W = $clog2(M + 1)
) (
    input  logic clk,
    input  logic reset,
    output logic empty
);

    logic [W-1:0] count_q;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= W'(M);
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign empty = (count_q == '0);

endmodule

// File: rtl/n64_rx.sv
// ----------------------------------------------------------------------------
// n64_rx
// Receiver for the N64 controller response frame. After an arm pulse it
// decodes NBITS pulse-width-encoded bits (MSB first) plus a stop bit from
// the one-wire data line, then presents the word with a one-cycle strobe.
// A silent line for TIMEOUT cycles aborts the frame with an error strobe.
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   start in  one-cycle arm pulse (ignored while busy)
//   din   in  raw, asynchronous data line (idle high)
//   data  out last successfully received word
//   valid out one-cycle pulse when data updates
//   busy  out high while a frame is being received
//   err   out one-cycle pulse on timeout
// ----------------------------------------------------------------------------
module n64_rx
    import n64_pkg::*;
#(
    parameter int US      = US_DEFAULT,
    parameter int NBITS   = 32,
    parameter int TIMEOUT = 5000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             din,
    output logic [NBITS-1:0] data,
    output logic             valid,
    output logic             busy,
    output logic             err
);

    localparam int BC_W  = $clog2(NBITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int SMP_W = $clog2(2 * US) + 1;
    localparam int SMP_M = sample_cycles(US) - 1;

    // Synchronizer and edge-detect history; all idle high.
    logic sync1_q, ds, ds_q;
    logic fall, rise;

    state_e            state_q, state_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [NBITS-1:0]  sreg_q, sreg_d;
    logic [NBITS-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              smp_empty;
    logic              counting;
    logic              timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            ds      <= 1'b1;
            ds_q    <= 1'b1;
        end else begin
            sync1_q <= din;
            ds      <= sync1_q;
            ds_q    <= ds;
        end
    end

    assign fall = ds_q & ~ds;
    assign rise = ~ds_q & ds;

    // Sample timer: reloaded on every falling edge, empty at the sample point.
    // System reset also reloads it so it never starts from an unknown count.
    counterM #(
        .M (SMP_M),
        .W (SMP_W)
    ) u_sample_timer (
        .clk   (clk),
        .reset (reset | fall),
        .empty (smp_empty)
    );

    assign counting    = (state_q != S_IDLE) && (state_q != S_SAMPLE);
    assign timeout_hit = counting && (to_q == TO_W'(TIMEOUT - 1));

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sreg_d   = sreg_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        to_d     = to_q;
        if (counting && (to_q != TO_W'(TIMEOUT))) begin
            to_d = to_q + TO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bitcnt_d = '0;
                    to_d     = '0;
                    state_d  = S_WAIT_FALL;
                end
            end
            S_WAIT_FALL: begin
                if (fall) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (smp_empty) begin
                    sreg_d = {sreg_q[NBITS-2:0], ds};
                    if (bitcnt_q != BC_W'(NBITS)) begin
                        bitcnt_d = bitcnt_q + BC_W'(1);
                    end
                    state_d = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                // A '1' bit's rising edge precedes the sample point, so the
                // end of the low phase is recognised by the line level; for a
                // '0' bit this is the rising edge itself.
                if (ds) begin
                    state_d = (bitcnt_q == BC_W'(NBITS)) ? S_STOP_FALL : S_WAIT_FALL;
                end
            end
            S_STOP_FALL: begin
                if (fall) state_d = S_STOP_RISE;
            end
            S_STOP_RISE: begin
                if (rise) begin
                    data_d  = sreg_q;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout overrides any same-cycle progress, keeping valid and err
        // mutually exclusive and leaving data untouched.
        if (timeout_hit) begin
            state_d = S_IDLE;
            data_d  = data_q;
            valid_d = 1'b0;
            err_d   = 1'b1;
        end

        if (state_d != state_q) begin
            to_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            to_q     <= '0;
            sreg_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            to_q     <= to_d;
            sreg_q   <= sreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_n64_rx.sv
// ----------------------------------------------------------------------------
// tb_n64_rx
// Directed bench for n64_rx: a controller model drives pulse-width-encoded
// frames on din, and each scenario task compares outputs against hand-
// computed values.
// ----------------------------------------------------------------------------
module tb_n64_rx;
    import n64_pkg::*;

    localparam int US      = 50;
    localparam int NBITS   = 32;
    localparam int TIMEOUT = 5000;
    localparam int BIT_CYC = BIT_PERIOD_US * US;   // 200 cycles per bit
    localparam int SHORT   = BIT_CYC / 4;          // 1 us
    localparam int LONG    = 3 * BIT_CYC / 4;      // 3 us

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             din;
    logic [NBITS-1:0] data;
    logic             valid;
    logic             busy;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    // Written only by the monitor below.
    int               vc = 0;
    int               ec = 0;
    int               bad_cnt = 0;
    logic [NBITS-1:0] got_q[$];

    always #10 clk = ~clk;

    n64_rx #(
        .US      (US),
        .NBITS   (NBITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (din),
        .data  (data),
        .valid (valid),
        .busy  (busy),
        .err   (err)
    );

    // Strobe monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vc++;
            got_q.push_back(data);
            if (busy !== 1'b0 || err !== 1'b0) bad_cnt++;
        end
        if (err === 1'b1) begin
            ec++;
            if (busy !== 1'b0) bad_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        din = 1'b0;
        tick(b ? SHORT : LONG);
        din = 1'b1;
        tick(b ? LONG : SHORT);
    endtask

    task automatic drive_stop();
        din = 1'b0;
        tick(SHORT);
        din = 1'b1;
    endtask

    task automatic send_word(input logic [NBITS-1:0] w);
        for (int i = NBITS - 1; i >= 0; i--) drive_bit(w[i]);
        drive_stop();
        tick(20);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;   // start coinciding with reset must be ignored
        din   = 1'b1;
        tick(3);
        start = 1'b0;
        reset = 1'b0;
        tick(1);
        n_checks++; if (data !== '0)   begin n_fail++; $display("FAIL reset_data: got %h want %h", data, 32'h0); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, S_IDLE); end
    endtask

    task automatic test_single();
        int v0 = vc;
        int e0 = ec;
        int q0 = got_q.size();
        pulse_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
        tick(2 * US);
        send_word(32'h8000_0000);
        n_checks++; if (vc - v0 != 1) begin n_fail++; $display("FAIL single_valid_count: got %0d want 1", vc - v0); end
        n_checks++; if (got_q.size() <= q0 || got_q[q0] !== 32'h8000_0000) begin n_fail++; $display("FAIL single_strobe_data: got %h want %h", data, 32'h8000_0000); end
        n_checks++; if (data !== 32'h8000_0000) begin n_fail++; $display("FAIL single_data: got %h want %h", data, 32'h8000_0000); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
        n_checks++; if (ec != e0) begin n_fail++; $display("FAIL single_no_err: got %0d want 0", ec - e0); end
    endtask

    task automatic test_back_to_back();
        int v0 = vc;
        int q0 = got_q.size();
        pulse_start();
        tick(2 * US);
        send_word(32'hFFFF_FFFF);
        pulse_start();
        tick(2 * US);
        send_word(32'h1234_5678);
        n_checks++; if (vc - v0 != 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d want 2", vc - v0); end
        n_checks++; if (got_q.size() < q0 + 2 || got_q[q0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_word0: want %h", 32'hFFFF_FFFF); end
        n_checks++; if (got_q.size() < q0 + 2 || got_q[q0+1] !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_word1: want %h", 32'h1234_5678); end
        n_checks++; if (data !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_data: got %h want %h", data, 32'h1234_5678); end
    endtask

    task automatic test_timeout_idle();
        int v0 = vc;
        int n  = 0;
        din = 1'b1;
        // WAIT_FALL is entered at the edge that samples start; err follows
        // exactly TIMEOUT edges later.
        pulse_start();
        while (err !== 1'b1 && n < TIMEOUT + 50) begin
            tick(1);
            n++;
        end
        n_checks++; if (n != TIMEOUT) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", n, TIMEOUT); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
        tick(1);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_width: got %b want 0", err); end
        n_checks++; if (data !== 32'h1234_5678) begin n_fail++; $display("FAIL timeout_data_kept: got %h want %h", data, 32'h1234_5678); end
        n_checks++; if (vc != v0) begin n_fail++; $display("FAIL timeout_no_valid: got %0d want 0", vc - v0); end
    endtask

    task automatic test_stuck_low();
        logic [NBITS-1:0] w = 32'hB2C0_0000;
        int v0 = vc;
        int e0 = ec;
        int n  = 0;
        pulse_start();
        tick(2 * US);
        for (int i = NBITS - 1; i >= NBITS - 10; i--) drive_bit(w[i]);
        // Line stuck low: 2 sync + 1 edge stage, 100-cycle sample timer, one
        // cycle into WAIT_RISE, then TIMEOUT cycles -> about TIMEOUT+103.
        din = 1'b0;
        while (err !== 1'b1 && n < TIMEOUT + 400) begin
            tick(1);
            n++;
        end
        n_checks++; if (n < TIMEOUT + 101 || n > TIMEOUT + 105) begin n_fail++; $display("FAIL stuck_err_latency: got %0d want %0d", n, TIMEOUT + 103); end
        n_checks++; if (data !== 32'h1234_5678) begin n_fail++; $display("FAIL stuck_data_kept: got %h want %h", data, 32'h1234_5678); end
        din = 1'b1;
        tick(20);
        pulse_start();
        tick(2 * US);
        send_word(32'h00FF_00FF);
        n_checks++; if (data !== 32'h00FF_00FF) begin n_fail++; $display("FAIL stuck_recover_data: got %h want %h", data, 32'h00FF_00FF); end
        n_checks++; if (vc - v0 != 1) begin n_fail++; $display("FAIL stuck_valid_count: got %0d want 1", vc - v0); end
        n_checks++; if (ec - e0 != 1) begin n_fail++; $display("FAIL stuck_err_count: got %0d want 1", ec - e0); end
    endtask

    task automatic test_double_start();
        logic [NBITS-1:0] w = 32'hA5C3_3C5A;
        int v0 = vc;
        int e0 = ec;
        pulse_start();
        tick(2 * US);
        for (int i = NBITS - 1; i >= 16; i--) drive_bit(w[i]);
        pulse_start();   // while busy: must be ignored
        for (int i = 15; i >= 0; i--) drive_bit(w[i]);
        drive_stop();
        tick(20);
        n_checks++; if (data !== 32'hA5C3_3C5A) begin n_fail++; $display("FAIL dstart_data: got %h want %h", data, 32'hA5C3_3C5A); end
        n_checks++; if (vc - v0 != 1) begin n_fail++; $display("FAIL dstart_valid_count: got %0d want 1", vc - v0); end
        n_checks++; if (ec != e0) begin n_fail++; $display("FAIL dstart_no_err: got %0d want 0", ec - e0); end
    endtask

    task automatic test_reset_mid();
        logic [NBITS-1:0] w = 32'h5A5A_A5A5;
        int v0 = vc;
        int e0 = ec;
        pulse_start();
        tick(2 * US);
        for (int i = NBITS - 1; i >= NBITS - 19; i--) drive_bit(w[i]);
        din = 1'b0;       // bit 20 low phase
        tick(30);
        reset = 1'b1;
        tick(1);
        n_checks++; if (data !== '0)    begin n_fail++; $display("FAIL rmid_data: got %h want %h", data, 32'h0); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", valid); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL rmid_err: got %b want 0", err); end
        n_checks++; if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL rmid_state: got %0d want %0d", dut.state_q, S_IDLE); end
        reset = 1'b0;
        tick(20);
        din = 1'b1;
        tick(SHORT);
        for (int i = NBITS - 21; i >= 0; i--) drive_bit(w[i]);
        drive_stop();
        tick(TIMEOUT + 20);
        n_checks++; if (vc != v0) begin n_fail++; $display("FAIL rmid_no_valid: got %0d want 0", vc - v0); end
        n_checks++; if (ec != e0) begin n_fail++; $display("FAIL rmid_no_err: got %0d want 0", ec - e0); end
        n_checks++; if (data !== '0) begin n_fail++; $display("FAIL rmid_data_after: got %h want %h", data, 32'h0); end
    endtask

    task automatic test_strobe_flags();
        n_checks++; if (bad_cnt != 0) begin n_fail++; $display("FAIL strobe_flags: got %0d bad strobes want 0", bad_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        din   = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout_idle();
        test_stuck_low();
        test_double_start();
        test_reset_mid();
        test_strobe_flags();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
